// File: rtl/id_hazard_unit.sv
// ID-stage hazard unit: load-use stall/bubble, EXE/MEM operand forwarding selects,
// and a saturating stall-cycle counter for performance debug.
module id_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic             e_regrt,
  input  logic [4:0]       e_rt,
  input  logic [4:0]       e_rd,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]       w_e_dst;
  logic             r_m_wreg;
  logic             r_m_m2reg;
  logic [4:0]       r_m_dst;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs_exe, w_rt_exe, w_rs_mem, w_rt_mem, w_load_use;

  assign w_e_dst = e_regrt ? e_rt : e_rd;

  // Register 0 is hardwired, so it never participates in a match.
  assign w_rs_exe = id_use_rs && (id_rs != 5'd0) && ewreg    && (id_rs == w_e_dst);
  assign w_rt_exe = id_use_rt && (id_rt != 5'd0) && ewreg    && (id_rt == w_e_dst);
  assign w_rs_mem = id_use_rs && (id_rs != 5'd0) && r_m_wreg && (id_rs == r_m_dst);
  assign w_rt_mem = id_use_rt && (id_rt != 5'd0) && r_m_wreg && (id_rt == r_m_dst);

  assign w_load_use = em2reg && (w_rs_exe || w_rt_exe);
  assign stall      = w_load_use;
  assign bubble     = w_load_use;
  assign stall_cnt  = r_stall_cnt;

  // EXE beats MEM; an EXE load match selects regfile since the stall hides it.
  always_comb begin
    fwd_a = 2'd0;
    if (w_rs_exe) begin
      if (!em2reg) fwd_a = 2'd1;
    end else if (w_rs_mem) begin
      fwd_a = r_m_m2reg ? 2'd3 : 2'd2;
    end
  end

  always_comb begin
    fwd_b = 2'd0;
    if (w_rt_exe) begin
      if (!em2reg) fwd_b = 2'd1;
    end else if (w_rt_mem) begin
      fwd_b = r_m_m2reg ? 2'd3 : 2'd2;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     w_state_next = w_load_use ? STALL : RUN;
      STALL:   w_state_next = w_load_use ? STALL : RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_wreg    <= 1'b0;
      r_m_m2reg   <= 1'b0;
      r_m_dst     <= 5'd0;
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_m_wreg  <= ewreg;
      r_m_m2reg <= em2reg;
      r_m_dst   <= w_e_dst;
      r_state   <= w_state_next;
      if (w_load_use && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed self-checking bench for id_hazard_unit; a second CNT_W=4 instance
// shares the stimulus to exercise counter saturation.
module tb_id_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, e_rt, e_rd;
  logic        id_use_rs, id_use_rt, ewreg, em2reg, e_regrt;
  logic        stall, bubble, stall_s, bubble_s;
  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ewreg(ewreg), .em2reg(em2reg),
    .e_regrt(e_regrt), .e_rt(e_rt), .e_rd(e_rd), .stall(stall), .bubble(bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  id_hazard_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ewreg(ewreg), .em2reg(em2reg),
    .e_regrt(e_regrt), .e_rt(e_rt), .e_rd(e_rd), .stall(stall_s), .bubble(bubble_s),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_exe(input logic w, input logic m2r, input logic regrt,
                         input logic [4:0] rt, input logic [4:0] rd);
    ewreg = w; em2reg = m2r; e_regrt = regrt; e_rt = rt; e_rd = rd;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with arbitrary ID fields, EXE empty
    rst = 1'b1;
    set_exe(1'b0, 1'b1, 1'b1, 5'd7, 5'd9);
    set_id(5'd7, 1'b1, 5'd9, 1'b1);
    #3;
    check("rst_stall", stall, 0);
    check("rst_bubble", bubble, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_cnt", stall_cnt, 0);
    tick();
    rst = 1'b0;

    // ALU-ALU: EXE writes r5 via rd
    set_exe(1'b1, 1'b0, 1'b0, 5'd9, 5'd5);
    set_id(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check("alu_fwd_a_exe", fwd_a, 1);
    check("alu_stall", stall, 0);
    check("alu_fwd_b", fwd_b, 0);
    tick();
    set_exe(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    check("alu_fwd_a_mem", fwd_a, 2);
    tick();

    // Load-use on rt = r8
    set_exe(1'b1, 1'b1, 1'b1, 5'd8, 5'd2);
    set_id(5'd0, 1'b0, 5'd8, 1'b1);
    #1;
    check("lu_stall", stall, 1);
    check("lu_bubble", bubble, 1);
    check("lu_fwd_b", fwd_b, 0);
    tick();
    set_exe(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    check("lu_stall_after", stall, 0);
    check("lu_bubble_aft", bubble, 0);
    check("lu_fwd_b_mem", fwd_b, 3);
    check("lu_cnt", stall_cnt, 1);
    tick();

    // Register 0 never matches, even for a load
    set_exe(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    set_id(5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("r0_fwd_a", fwd_a, 0);
    check("r0_fwd_b", fwd_b, 0);
    check("r0_stall", stall, 0);
    em2reg = 1'b1;
    #1;
    check("r0_load_stall", stall, 0);
    tick();

    // Priority: MEM has load to r3, EXE has ALU write to r3
    set_exe(1'b1, 1'b1, 1'b0, 5'd0, 5'd3);
    set_id(5'd3, 1'b0, 5'd3, 1'b0);
    #1;
    check("unused_stall", stall, 0);
    tick();
    set_exe(1'b1, 1'b0, 1'b0, 5'd0, 5'd3);
    set_id(5'd3, 1'b1, 5'd3, 1'b0);
    #1;
    check("prio_fwd_a", fwd_a, 1);
    check("unused_fwd_b", fwd_b, 0);
    tick();
    set_exe(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    set_id(5'd3, 1'b1, 5'd3, 1'b1);
    #1;
    check("mem_alu_fwd_a", fwd_a, 2);
    check("mem_alu_fwd_b", fwd_b, 2);
    tick();

    // MEM load data selected for rs
    set_exe(1'b1, 1'b1, 1'b1, 5'd7, 5'd1);
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_exe(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    set_id(5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    check("mem_ld_fwd_a", fwd_a, 3);
    tick();

    // Both sources depend on one load: one stall covers both
    set_exe(1'b1, 1'b1, 1'b1, 5'd4, 5'd0);
    set_id(5'd4, 1'b1, 5'd4, 1'b1);
    #1;
    check("both_stall", stall, 1);
    check("both_fwd_a", fwd_a, 0);
    check("both_fwd_b", fwd_b, 0);
    tick();
    set_exe(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    check("both_stall_aft", stall, 0);
    check("both_fwd_a_ld", fwd_a, 3);
    check("both_fwd_b_ld", fwd_b, 3);
    check("both_cnt", stall_cnt, 2);
    tick();

    // Reset asserted mid-stall with a live MEM forward
    set_exe(1'b1, 1'b0, 1'b0, 5'd0, 5'd6);
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_exe(1'b1, 1'b1, 1'b1, 5'd9, 5'd0);
    set_id(5'd6, 1'b1, 5'd9, 1'b1);
    #1;
    check("mid_stall", stall, 1);
    check("mid_fwd_a", fwd_a, 2);
    tick();
    check("mid_cnt_pre", stall_cnt, 3);
    set_exe(1'b1, 1'b1, 1'b1, 5'd9, 5'd0);
    #1;
    rst = 1'b1;
    ewreg = 1'b0;
    em2reg = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_fwd_a", fwd_a, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_cnt_s", stall_cnt_s, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_fwd_a", fwd_a, 0);
    tick();
    check("post_rst_cnt", stall_cnt, 0);

    // Saturation: 20 load-use hazards, each followed by its bubble
    for (int i = 0; i < 20; i++) begin
      set_exe(1'b1, 1'b1, 1'b1, 5'd8, 5'd0);
      set_id(5'd0, 1'b0, 5'd8, 1'b1);
      #1;
      check("sat_stall", stall_s, 1);
      tick();
      set_exe(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
    end
    check("sat_cnt_w4", stall_cnt_s, 15);
    check("sat_cnt_w16", stall_cnt, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
